// File: rtl/vx_raster_req_arb.sv
// Round-robin merge of raster stamp streams into one registered request port, with frame-done aggregation.
// Optional performance counters are compiled in when RASTER_ARB_PERF_EN is defined.
module vx_raster_req_arb #(
  parameter int NUM_INPUTS   = 4,
  parameter int OUTPUT_QUADS = 4,
  parameter int STAMP_BITS   = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_INPUTS-1:0]                      in_valid,
  input  logic [NUM_INPUTS*OUTPUT_QUADS*STAMP_BITS-1:0] in_stamps,
  input  logic [NUM_INPUTS-1:0]                      in_done,
  output logic [NUM_INPUTS-1:0]                      in_ready,
  output logic                                       out_valid,
  output logic [OUTPUT_QUADS*STAMP_BITS-1:0]         out_stamps,
  output logic                                       out_done,
  input  logic                                       out_ready
`ifdef RASTER_ARB_PERF_EN
  ,
  output logic [31:0]                                perf_stall_cycles,
  output logic [31:0]                                perf_stamp_beats
`endif
);

  localparam int BEAT_W = OUTPUT_QUADS * STAMP_BITS;
  localparam int PTR_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                  r_out_vld_p1;
  logic                  r_out_done_p1;
  logic [BEAT_W-1:0]     r_out_stamps_p1;
  logic [NUM_INPUTS-1:0] r_done_mask;
  logic [PTR_W-1:0]      r_rr_ptr;

  logic                  w_can_load;
  logic                  w_out_fire;
  logic                  w_frame_fire;
  logic                  w_frame_load;
  logic [NUM_INPUTS-1:0] w_elig;
  logic [NUM_INPUTS-1:0] w_done_acc;
  logic [NUM_INPUTS-1:0] w_stamp_req;
  logic [NUM_INPUTS-1:0] w_grant_oh;
  logic [PTR_W-1:0]      w_grant;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W:0]        w_sum;
  logic [PTR_W-1:0]      w_next_ptr;
  logic                  w_grant_vld;
  logic                  w_stamp_acc;
  logic [BEAT_W-1:0]     w_sel_stamps;

  assign w_can_load   = !r_out_vld_p1 || out_ready;
  assign w_out_fire   = r_out_vld_p1 && out_ready;
  assign w_frame_fire = w_out_fire && r_out_done_p1;
  assign w_elig       = in_valid & ~r_done_mask;
  assign w_done_acc   = w_elig & in_done;
  assign w_stamp_req  = w_elig & ~in_done;
  // The done beat being handed off must not be re-issued while its mask clears.
  assign w_frame_load = (&r_done_mask) && w_can_load && !(r_out_vld_p1 && r_out_done_p1);

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_INPUTS)) w_sum = w_sum - (PTR_W+1)'(NUM_INPUTS);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_grant_vld && w_stamp_req[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  assign w_stamp_acc = w_grant_vld && w_can_load;
  assign w_next_ptr  = (w_grant == PTR_W'(NUM_INPUTS-1)) ? '0 : w_grant + PTR_W'(1);

  always_comb begin
    w_grant_oh   = '0;
    w_sel_stamps = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_grant_oh[i] = w_stamp_acc && (w_grant == PTR_W'(i));
      if (w_grant == PTR_W'(i)) w_sel_stamps = in_stamps[i*BEAT_W +: BEAT_W];
    end
  end

  assign in_ready = reset ? '0 : (w_done_acc | w_grant_oh);

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_vld_p1    <= 1'b0;
      r_out_done_p1   <= 1'b0;
      r_out_stamps_p1 <= '0;
    end else if (w_stamp_acc) begin
      r_out_vld_p1    <= 1'b1;
      r_out_done_p1   <= 1'b0;
      r_out_stamps_p1 <= w_sel_stamps;
    end else if (w_frame_load) begin
      r_out_vld_p1    <= 1'b1;
      r_out_done_p1   <= 1'b1;
      r_out_stamps_p1 <= '0;
    end else if (w_out_fire) begin
      r_out_vld_p1    <= 1'b0;
      r_out_done_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_mask <= '0;
      r_rr_ptr    <= '0;
    end else if (w_frame_fire) begin
      r_done_mask <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_done_mask <= r_done_mask | w_done_acc;
      if (w_stamp_acc) r_rr_ptr <= w_next_ptr;
    end
  end

  assign out_valid  = r_out_vld_p1;
  assign out_done   = r_out_done_p1;
  assign out_stamps = r_out_stamps_p1;

`ifdef RASTER_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_beats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_beats <= '0;
    end else begin
      if (r_out_vld_p1 && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_out_fire && !r_out_done_p1) r_perf_beats <= r_perf_beats + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_stamp_beats  = r_perf_beats;
`endif

endmodule

// File: tb/tb_vx_raster_req_arb.sv
// Directed table-driven bench for vx_raster_req_arb (4 sources, 32-bit beats).
module tb_vx_raster_req_arb;
  localparam int N  = 4;
  localparam int Q  = 2;
  localparam int SB = 16;
  localparam int BW = Q * SB;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*BW-1:0] in_stamps;
  logic [N-1:0]    in_done;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [BW-1:0]   out_stamps;
  logic            out_done;
  logic            out_ready;
`ifdef RASTER_ARB_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_stamp_beats;
`endif

  always #5 clk = ~clk;

  vx_raster_req_arb #(.NUM_INPUTS(N), .OUTPUT_QUADS(Q), .STAMP_BITS(SB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_stamps(in_stamps), .in_done(in_done), .in_ready(in_ready),
    .out_valid(out_valid), .out_stamps(out_stamps), .out_done(out_done), .out_ready(out_ready)
`ifdef RASTER_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_stamp_beats(perf_stamp_beats)
`endif
  );

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  d;
    logic [15:0] base;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic        e_od;
    logic [31:0] e_os;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Source i presents beat {base, i}.
  task automatic drive(input logic [3:0] v, input logic [3:0] d, input logic [15:0] base,
                       input logic ordy);
    in_valid  = v;
    in_done   = d;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_stamps[i*BW +: BW] = {base, 16'(i)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic od, input logic [31:0] os);
    chk({name, "_ov"}, {31'd0, out_valid}, {31'd0, ov});
    if (ov) begin
      chk({name, "_od"}, {31'd0, out_done}, {31'd0, od});
      chk({name, "_os"}, out_stamps, os);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 4'b0000, 16'hA000, 1'b1, 4'b0001, 1'b1, 1'b0, 32'hA000_0000};
    vecs[1]  = '{4'b0001, 4'b0000, 16'hB000, 1'b1, 4'b0001, 1'b1, 1'b0, 32'hB000_0000};
    vecs[2]  = '{4'b0001, 4'b0001, 16'h0000, 1'b1, 4'b0001, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{4'b1110, 4'b1110, 16'h0000, 1'b1, 4'b1110, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{4'b0001, 4'b0000, 16'hC000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{4'b0001, 4'b0000, 16'hC000, 1'b1, 4'b0001, 1'b1, 1'b0, 32'hC000_0000};
    vecs[7]  = '{4'b1111, 4'b0000, 16'hD000, 1'b1, 4'b0010, 1'b1, 1'b0, 32'hD000_0001};
    vecs[8]  = '{4'b1111, 4'b0000, 16'hD000, 1'b1, 4'b0100, 1'b1, 1'b0, 32'hD000_0002};
    vecs[9]  = '{4'b1111, 4'b0000, 16'hD000, 1'b1, 4'b1000, 1'b1, 1'b0, 32'hD000_0003};
    vecs[10] = '{4'b1111, 4'b0000, 16'hD000, 1'b1, 4'b0001, 1'b1, 1'b0, 32'hD000_0000};
    vecs[11] = '{4'b1111, 4'b0000, 16'hD000, 1'b1, 4'b0010, 1'b1, 1'b0, 32'hD000_0001};
    vecs[12] = '{4'b1011, 4'b0011, 16'hE000, 1'b1, 4'b1011, 1'b1, 1'b0, 32'hE000_0003};
    vecs[13] = '{4'b0001, 4'b0000, 16'hF000, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{4'b0101, 4'b0100, 16'hF000, 1'b1, 4'b0100, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{4'b1001, 4'b0000, 16'h1200, 1'b1, 4'b1000, 1'b1, 1'b0, 32'h1200_0003};
    vecs[16] = '{4'b1001, 4'b1000, 16'h1300, 1'b1, 4'b1000, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{4'b0001, 4'b0000, 16'h1400, 1'b1, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[18] = '{4'b0001, 4'b0000, 16'h1400, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0};
    vecs[19] = '{4'b0001, 4'b0000, 16'h1400, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[20] = '{4'b0001, 4'b0000, 16'h1400, 1'b1, 4'b0001, 1'b1, 1'b0, 32'h1400_0000};

    reset = 1'b1;
    drive(4'b0000, 4'b0000, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_od", {31'd0, out_done}, 32'd0);
    chk("rst_os", out_stamps, 32'd0);
    drive(4'b1111, 4'b0000, 16'h5A5A, 1'b1);
    #1;
    chk("rst_rdy", {28'd0, in_ready}, 32'd0);
    drive(4'b0000, 4'b0000, 16'h0, 1'b1);
    reset = 1'b0;

    for (int k = 0; k < 21; k++) begin
      drive(vecs[k].v, vecs[k].d, vecs[k].base, vecs[k].ordy);
      #1;
      chk($sformatf("v%0d_rdy", k), {28'd0, in_ready}, {28'd0, vecs[k].e_rdy});
      step();
      chk_out($sformatf("v%0d", k), vecs[k].e_ov, vecs[k].e_od, vecs[k].e_os);
    end

    // Stamp held through a 5-cycle consumer stall
    drive(4'b0100, 4'b0000, 16'h5500, 1'b1);
    #1;
    chk("stall_load_rdy", {28'd0, in_ready}, 32'b0100);
    step();
    chk_out("stall_load", 1'b1, 1'b0, 32'h5500_0002);
    drive(4'b0100, 4'b0000, 16'h6600, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_rdy", c), {28'd0, in_ready}, 32'd0);
      step();
      chk_out($sformatf("stall%0d", c), 1'b1, 1'b0, 32'h5500_0002);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_rdy", {28'd0, in_ready}, 32'b0100);
    step();
    chk_out("unstall", 1'b1, 1'b0, 32'h6600_0002);
    drive(4'b0000, 4'b0000, 16'h0, 1'b1);
    step();
    chk_out("drain", 1'b0, 1'b0, 32'h0);

    // All sources done, frame-done beat held under a 3-cycle stall
    drive(4'b1111, 4'b1111, 16'h0, 1'b1);
    #1;
    chk("alldone_rdy", {28'd0, in_ready}, 32'b1111);
    step();
    chk_out("alldone", 1'b0, 1'b0, 32'h0);
    drive(4'b0000, 4'b0000, 16'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out($sformatf("fdhold%0d", c), 1'b1, 1'b1, 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk_out("fdfire", 1'b0, 1'b0, 32'h0);
    drive(4'b1111, 4'b0000, 16'h7700, 1'b1);
    #1;
    chk("ptr0_rdy", {28'd0, in_ready}, 32'b0001);
    step();
    chk_out("ptr0", 1'b1, 1'b0, 32'h7700_0000);

    // Asynchronous reset with a buffered beat and a partial done mask
    drive(4'b0011, 4'b0010, 16'h8800, 1'b0);
    #1;
    chk("prerst_rdy", {28'd0, in_ready}, 32'b0010);
    step();
    chk_out("prerst", 1'b1, 1'b0, 32'h7700_0000);
    #2 reset = 1'b1;
    #1;
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_rdy", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(4'b0010, 4'b0000, 16'h9900, 1'b1);
    #1;
    chk("postrst_rdy", {28'd0, in_ready}, 32'b0010);
    step();
    chk_out("postrst", 1'b1, 1'b0, 32'h9900_0001);

`ifdef RASTER_ARB_PERF_EN
    drive(4'b0001, 4'b0000, 16'hAA00, 1'b1);
    repeat (9) step();
    chk_out("perf_run", 1'b1, 1'b0, 32'hAA00_0000);
    drive(4'b0000, 4'b0000, 16'h0, 1'b0);
    repeat (4) step();
    drive(4'b0000, 4'b0000, 16'h0, 1'b1);
    step();
    chk("perf_stall", perf_stall_cycles, 32'd4);
    chk("perf_beats", perf_stamp_beats, 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
